// File: rtl/alu_arbiter_if.sv
// Requester and ALU handshake bundle for alu_arbiter.
// master: the arbiter side; slave: the requesters and the ALU.
interface alu_arbiter_if #(
  parameter int REG_SIZE = 8,
  parameter int NUM_REQ  = 2
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_valid;
  logic [2*NUM_REQ-1:0]        req_operation;
  logic [REG_SIZE*NUM_REQ-1:0] req_op1;
  logic [REG_SIZE*NUM_REQ-1:0] req_op2;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [NUM_REQ-1:0]          rsp_err;
  logic [REG_SIZE-1:0]         rsp_res;
  logic [1:0]                  alu_operation;
  logic [REG_SIZE-1:0]         alu_op1;
  logic [REG_SIZE-1:0]         alu_op2;
  logic                        alu_req;
  logic                        alu_done;
  logic [REG_SIZE-1:0]         alu_res;
  logic                        busy;
  logic [GW-1:0]               grant_id;

  modport master (
    input  req_valid, req_operation, req_op1, req_op2, alu_done, alu_res,
    output req_ready, rsp_valid, rsp_err, rsp_res,
    output alu_operation, alu_op1, alu_op2, alu_req, busy, grant_id
  );

  modport slave (
    output req_valid, req_operation, req_op1, req_op2, alu_done, alu_res,
    input  req_ready, rsp_valid, rsp_err, rsp_res,
    input  alu_operation, alu_op1, alu_op2, alu_req, busy, grant_id
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters, with a
// watchdog that aborts an operation whose alu_done never arrives.
module alu_arbiter #(
  parameter int REG_SIZE = 8,
  parameter int NUM_REQ  = 2,
  parameter int TIMEOUT  = 16
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [1:0]          op_q, op_d;
  logic [REG_SIZE-1:0] op1_q, op1_d;
  logic [REG_SIZE-1:0] op2_q, op2_d;
  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic [REG_SIZE-1:0] res_q, res_d;
  logic                err_q, err_d;

  logic                win_found_s;
  logic [GW-1:0]       win_idx_s, cand_idx_s;

  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]  rsp_err_q, rsp_err_d;
  logic [REG_SIZE-1:0] rsp_res_q, rsp_res_d;
  logic                alu_req_q, alu_req_d;
  logic                busy_q, busy_d;
  logic [GW-1:0]       grant_id_q, grant_id_d;

  // Round-robin search: walk from lowest to highest priority so the
  // requester right after the last winner is assigned last and wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_idx_s  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand_idx_s  = GW'((int'(last_grant_q) + i) % NUM_REQ);
      win_found_s = win_found_s | bus.req_valid[cand_idx_s];
      win_idx_s   = bus.req_valid[cand_idx_s] ? cand_idx_s : win_idx_s;
    end
  end

  // Watchdog increment saturates at the limit instead of wrapping.
  always_comb begin
    cnt_inc_s = (cnt_q >= CNT_LIMIT) ? cnt_q : (cnt_q + CW'(1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d      = ISSUE;
          last_grant_d = win_idx_s;
          op_d         = bus.req_operation[int'(win_idx_s)*2 +: 2];
          op1_d        = bus.req_op1[int'(win_idx_s)*REG_SIZE +: REG_SIZE];
          op2_d        = bus.req_op2[int'(win_idx_s)*REG_SIZE +: REG_SIZE];
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_inc_s;
        // A done landing on the timeout cycle still counts as success.
        if (bus.alu_done) begin
          res_d   = bus.alu_res;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_inc_s == CNT_LIMIT) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes from a flop.
  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_err_d   = '0;
    rsp_res_d   = '0;
    alu_req_d   = 1'b0;
    busy_d      = (state_d != IDLE);
    grant_id_d  = (state_d == ISSUE) ? last_grant_d : grant_id_q;
    case (state_d)
      IDLE: begin
        alu_req_d = 1'b0;
      end
      ISSUE: begin
        alu_req_d                 = 1'b1;
        req_ready_d[last_grant_d] = 1'b1;
      end
      WAIT: begin
        alu_req_d = 1'b0;
      end
      RESP: begin
        rsp_valid_d[last_grant_d] = 1'b1;
        rsp_err_d[last_grant_d]   = err_d;
        rsp_res_d                 = res_d;
      end
      default: begin
        alu_req_d = 1'b0;
      end
    endcase
  end

  // Operand latches, watchdog, captured result and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_IDX;
      op_q         <= 2'd0;
      op1_q        <= '0;
      op2_q        <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      err_q        <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp_res_q    <= '0;
      alu_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_res_q    <= rsp_res_d;
      alu_req_q    <= alu_req_d;
      busy_q       <= busy_d;
      grant_id_q   <= grant_id_d;
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_res       = rsp_res_q;
  assign bus.alu_operation = op_q;
  assign bus.alu_op1       = op1_q;
  assign bus.alu_op2       = op2_q;
  assign bus.alu_req       = alu_req_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_id_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses go into a scoreboard
// queue when a request is driven and are popped when rsp_valid appears.
module tb_alu_arbiter;
  localparam int REG_SIZE = 8;
  localparam int NUM_REQ  = 2;
  localparam int TIMEOUT  = 16;

  typedef struct {
    int         idx;
    logic       err;
    logic [7:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  exp_t sb_q[$];

  int         alu_delay;
  int         countdown;
  logic       auto_done;
  logic [7:0] auto_res;
  logic [7:0] pend_res;
  logic       man_done;
  logic [7:0] man_res;
  int         ic, rc;

  alu_arbiter_if #(.REG_SIZE(REG_SIZE), .NUM_REQ(NUM_REQ)) bus ();

  alu_arbiter #(.REG_SIZE(REG_SIZE), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.alu_done = auto_done | man_done;
  assign bus.alu_res  = man_done ? man_res : auto_res;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return (b == 8'd0) ? 8'hFF : a / b;
    endcase
  endfunction

  // ALU model: answers alu_req after alu_delay cycles (0 = never).
  initial begin : alu_model
    auto_done = 1'b0;
    auto_res  = 8'h00;
    pend_res  = 8'h00;
    countdown = 0;
    forever begin
      @(posedge clk); #1;
      auto_done = 1'b0;
      if (rst === 1'b1) begin
        countdown = 0;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          auto_done = 1'b1;
          auto_res  = pend_res;
        end
      end
      if (bus.alu_req === 1'b1 && alu_delay > 0) begin
        countdown = alu_delay;
        pend_res  = alu_fn(bus.alu_operation, bus.alu_op1, bus.alu_op2);
      end
    end
  end

  initial begin : global_guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests run %0d", tests_run);
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_req(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[idx]            = 1'b1;
    bus.req_operation[2*idx +: 2] = op;
    bus.req_op1[8*idx +: 8]       = a;
    bus.req_op2[8*idx +: 8]       = b;
  endtask

  task automatic push_exp(input int idx, input logic err, input logic [7:0] res);
    exp_t e;
    e.idx = idx;
    e.err = err;
    e.res = res;
    sb_q.push_back(e);
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_unexpected_rsp"}, 32'(bus.rsp_valid), 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1 << e.idx);
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), e.err ? (32'd1 << e.idx) : 32'd0);
      chk({tag, "_rsp_res"}, 32'(bus.rsp_res), 32'(e.res));
      chk({tag, "_grant_id"}, 32'(bus.grant_id), 32'(e.idx));
    end
  endtask

  // Steps until a response shows up; drops the winner's request after
  // req_ready unless hold is set. Records ISSUE and RESP cycle numbers.
  task automatic wait_rsp(input string tag, input int budget, input bit hold,
                          output int issue_cyc, output int rsp_cyc);
    bit                 found = 1'b0;
    bit                 drop  = 1'b0;
    logic [NUM_REQ-1:0] rdy   = '0;
    issue_cyc = -1;
    rsp_cyc   = -1;
    for (int n = 0; n < budget && !found; n++) begin
      step();
      if (drop) begin
        bus.req_valid = bus.req_valid & ~rdy;
        drop = 1'b0;
      end
      @(negedge clk);
      if (bus.req_ready != '0) begin
        rdy  = bus.req_ready;
        drop = !hold;
      end
      if (bus.alu_req === 1'b1) issue_cyc = cyc;
      if (bus.rsp_valid != '0) begin
        check_rsp(tag);
        rsp_cyc = cyc;
        found   = 1'b1;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(found), 32'd1);
  endtask

  initial begin : stimulus
    rst               = 1'b1;
    bus.req_valid     = '0;
    bus.req_operation = '0;
    bus.req_op1       = '0;
    bus.req_op2       = '0;
    man_done          = 1'b0;
    man_res           = 8'h00;
    alu_delay         = 1;
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy",      32'(bus.busy),          32'd0);
    chk("rst_req_ready", 32'(bus.req_ready),     32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid),     32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),       32'd0);
    chk("rst_rsp_res",   32'(bus.rsp_res),       32'd0);
    chk("rst_alu_req",   32'(bus.alu_req),       32'd0);
    chk("rst_alu_op",    32'(bus.alu_operation), 32'd0);
    chk("rst_alu_op1",   32'(bus.alu_op1),       32'd0);
    chk("rst_alu_op2",   32'(bus.alu_op2),       32'd0);
    chk("rst_grant_id",  32'(bus.grant_id),      32'd0);

    // Single op: 5 + 3, ALU done one cycle after alu_req
    step();
    drive_req(0, 2'b00, 8'h05, 8'h03);
    push_exp(0, 1'b0, 8'h08);
    @(negedge clk);
    chk("t1_c0_busy", 32'(bus.busy), 32'd0);
    step();
    @(negedge clk);
    chk("t1_c1_req_ready", 32'(bus.req_ready),     32'd1);
    chk("t1_c1_alu_req",   32'(bus.alu_req),       32'd1);
    chk("t1_c1_alu_op",    32'(bus.alu_operation), 32'd0);
    chk("t1_c1_alu_op1",   32'(bus.alu_op1),       32'h05);
    chk("t1_c1_alu_op2",   32'(bus.alu_op2),       32'h03);
    chk("t1_c1_busy",      32'(bus.busy),          32'd1);
    chk("t1_c1_grant",     32'(bus.grant_id),      32'd0);
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_c2_alu_req",   32'(bus.alu_req),   32'd0);
    chk("t1_c2_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check_rsp("t1_c3");
    step();
    @(negedge clk);
    chk("t1_c4_busy",      32'(bus.busy),      32'd0);
    chk("t1_c4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t1_c4_rsp_res",   32'(bus.rsp_res),   32'd0);

    // Spurious done in IDLE and in ISSUE
    step();
    man_done = 1'b1;
    man_res  = 8'h77;
    step();
    man_done = 1'b0;
    @(negedge clk);
    chk("t2_idle_busy",      32'(bus.busy),      32'd0);
    chk("t2_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    alu_delay = 2;
    step();
    drive_req(0, 2'b00, 8'h01, 8'h02);
    push_exp(0, 1'b0, 8'h03);
    step();
    man_done = 1'b1;
    man_res  = 8'h99;
    @(negedge clk);
    chk("t2_issue_alu_req", 32'(bus.alu_req), 32'd1);
    step();
    man_done      = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("t2_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    wait_rsp("t2", 10, 1'b0, ic, rc);

    // Contention: both requesters held for four ops
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive_req(0, 2'b10, 8'd7, 8'd6);
    drive_req(1, 2'b11, 8'd100, 8'd7);
    push_exp(0, 1'b0, 8'h2A);
    push_exp(1, 1'b0, 8'h0E);
    push_exp(0, 1'b0, 8'h2A);
    push_exp(1, 1'b0, 8'h0E);
    for (int k = 0; k < 4; k++) begin
      wait_rsp($sformatf("t3_op%0d", k), 12, 1'b1, ic, rc);
    end
    step();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t3_after_busy", 32'(bus.busy), 32'd0);

    // Timeout: the ALU never answers
    alu_delay = 0;
    step();
    drive_req(1, 2'b00, 8'h01, 8'h01);
    push_exp(1, 1'b1, 8'h00);
    wait_rsp("t4", 30, 1'b0, ic, rc);
    chk("t4_latency", 32'(rc - ic), 32'd17);
    step();
    @(negedge clk);
    chk("t4_idle_busy", 32'(bus.busy), 32'd0);

    // Done arriving on the timeout cycle wins
    alu_delay = 16;
    step();
    drive_req(0, 2'b00, 8'hA0, 8'h0A);
    push_exp(0, 1'b0, 8'hAA);
    wait_rsp("t5", 30, 1'b0, ic, rc);
    chk("t5_latency", 32'(rc - ic), 32'd17);

    // Reset during WAIT abandons the op; requester 0 wins afterwards
    alu_delay = 0;
    step();
    drive_req(1, 2'b01, 8'h09, 8'h04);
    step();
    step();
    bus.req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy",      32'(bus.busy),      32'd0);
    chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_rst_alu_req",   32'(bus.alu_req),   32'd0);
    chk("t6_rst_alu_op1",   32'(bus.alu_op1),   32'd0);
    chk("t6_rst_grant_id",  32'(bus.grant_id),  32'd0);
    step();
    man_done = 1'b1;
    man_res  = 8'h55;
    step();
    man_done = 1'b0;
    @(negedge clk);
    chk("t6_late_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t6_late_busy",      32'(bus.busy),      32'd0);
    alu_delay = 1;
    step();
    drive_req(0, 2'b00, 8'h02, 8'h03);
    drive_req(1, 2'b01, 8'h09, 8'h02);
    push_exp(0, 1'b0, 8'h05);
    push_exp(1, 1'b0, 8'h07);
    wait_rsp("t6_first", 10, 1'b0, ic, rc);
    wait_rsp("t6_second", 10, 1'b0, ic, rc);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
